// File: rtl/arm_multicycle_controller_if.sv
// Decode inputs and datapath controls shared between the multicycle ARM
// controller (slave) and the datapath or bench that drives it (master).
interface arm_multicycle_controller_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;
    logic [3:0] State;

    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, IRWrite, RegWrite, MemWrite,
        output AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        output ImmSrc, RegSrc, ALUControl, State
    );

    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, IRWrite, RegWrite, MemWrite,
        input  AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        input  ImmSrc, RegSrc, ALUControl, State
    );
endinterface

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control unit: state sequencer, ALU decode, NZCV flags
// and conditional-execution gating of the datapath write enables.
module arm_multicycle_controller (
    input  logic                          clk,
    input  logic                          reset,
    arm_multicycle_controller_if.slave    bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_flags;
    logic       r_condex;

    logic       w_nextpc;
    logic       w_branch;
    logic       w_regw_raw;
    logic       w_regw;
    logic       w_memw;
    logic       w_aluop;
    logic       w_adrsrc;
    logic       w_srca;
    logic [1:0] w_srcb;
    logic [1:0] w_rs;

    logic [3:0] w_cmd;
    logic       w_s;
    logic [1:0] w_aluctl_dec;
    logic       w_nowrite;
    logic       w_addsub;
    logic       w_is_cmp;
    logic [1:0] w_flagw;
    logic       w_condex;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    assign w_cmd = bus.Funct[4:1];
    assign w_s   = bus.Funct[0];
    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_next = S_FETCH;
        unique case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                unique case (bus.Op)
                    2'b00:   w_next = bus.Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_nextpc   = 1'b0;
        w_branch   = 1'b0;
        w_regw_raw = 1'b0;
        w_memw     = 1'b0;
        w_aluop    = 1'b0;
        w_adrsrc   = 1'b0;
        w_srca     = 1'b0;
        w_srcb     = 2'b00;
        w_rs       = 2'b00;
        unique case (r_state)
            S_FETCH: begin
                w_srca   = 1'b1;
                w_srcb   = 2'b10;
                w_rs     = 2'b10;
                w_nextpc = 1'b1;
            end
            S_DECODE: begin
                w_srca = 1'b1;
                w_srcb = 2'b10;
                w_rs   = 2'b10;
            end
            S_MEMADR: w_srcb = 2'b01;
            S_MEMRD:  w_adrsrc = 1'b1;
            S_MEMWB: begin
                w_rs       = 2'b01;
                w_regw_raw = 1'b1;
            end
            S_MEMWR: begin
                w_adrsrc = 1'b1;
                w_memw   = 1'b1;
            end
            S_EXECR:  w_aluop = 1'b1;
            S_EXECI: begin
                w_srcb  = 2'b01;
                w_aluop = 1'b1;
            end
            S_ALUWB:  w_regw_raw = 1'b1;
            S_BRANCH: begin
                w_srcb   = 2'b01;
                w_rs     = 2'b10;
                w_branch = 1'b1;
            end
            default: ;
        endcase
    end

    // Non-writing commands (CMP, unsupported) must not touch the register file.
    always_comb begin
        w_aluctl_dec = 2'b00;
        w_nowrite    = 1'b0;
        unique case (w_cmd)
            4'b0100: w_aluctl_dec = 2'b00;
            4'b0010: w_aluctl_dec = 2'b01;
            4'b0000: w_aluctl_dec = 2'b10;
            4'b1100: w_aluctl_dec = 2'b11;
            4'b1010: begin
                w_aluctl_dec = 2'b01;
                w_nowrite    = 1'b1;
            end
            default: w_nowrite = 1'b1;
        endcase
    end

    assign w_addsub = (w_cmd == 4'b0100) | (w_cmd == 4'b0010);
    assign w_is_cmp = (w_cmd == 4'b1010);

    always_comb begin
        w_flagw = 2'b00;
        if (w_aluop)
            w_flagw = w_is_cmp ? 2'b11 : {w_s, w_s & w_addsub};
    end

    assign w_regw = w_regw_raw &
                    ~((r_state == S_ALUWB) & (bus.Op == 2'b00) & w_nowrite);

    always_comb begin
        w_condex = 1'b0;
        unique case (bus.Cond)
            4'h0: w_condex = w_z;
            4'h1: w_condex = ~w_z;
            4'h2: w_condex = w_c;
            4'h3: w_condex = ~w_c;
            4'h4: w_condex = w_n;
            4'h5: w_condex = ~w_n;
            4'h6: w_condex = w_v;
            4'h7: w_condex = ~w_v;
            4'h8: w_condex = w_c & ~w_z;
            4'h9: w_condex = ~w_c | w_z;
            4'hA: w_condex = (w_n == w_v);
            4'hB: w_condex = (w_n != w_v);
            4'hC: w_condex = ~w_z & (w_n == w_v);
            4'hD: w_condex = w_z | (w_n != w_v);
            4'hE: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_flags  <= 4'b0000;
            r_condex <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_condex <= w_condex;
            if (((r_state == S_EXECR) | (r_state == S_EXECI)) & r_condex) begin
                if (w_flagw[1])
                    r_flags[3:2] <= bus.ALUFlags[3:2];
                if (w_flagw[0])
                    r_flags[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    // Enables are masked while reset is held so the FETCH strobes stay quiet.
    assign bus.PCWrite    = ~reset & (w_nextpc | (r_condex & (w_branch |
                            (w_regw & (bus.Rd == 4'd15)))));
    assign bus.IRWrite    = ~reset & (r_state == S_FETCH);
    assign bus.RegWrite   = ~reset & w_regw & r_condex;
    assign bus.MemWrite   = ~reset & w_memw & r_condex;
    assign bus.AdrSrc     = w_adrsrc;
    assign bus.ALUSrcA    = w_srca;
    assign bus.ALUSrcB    = w_srcb;
    assign bus.ResultSrc  = w_rs;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.ALUControl = w_aluop ? w_aluctl_dec : 2'b00;
    assign bus.State      = r_state;

endmodule

// File: doc/arm_multicycle_controller.md
# arm_multicycle_controller

Control unit for the multicycle variant of the ARM core. It sequences the shared instruction/data memory, the single ALU and the register file across several cycles per instruction. It decodes Cond/Op/Funct/Rd from the instruction register and holds the NZCV flag register. It drives every enable and mux select of the multicycle datapath.

## Interface
- No parameters; the ISA subset is fixed: ADD, SUB, AND, ORR, CMP (register or immediate), LDR, STR (immediate offset), B.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Cond  in  4  Instr[31:28].
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (or L for memory ops).
- Rd  in  4  Instr[15:12].
- ALUFlags  in  4  {N,Z,C,V} from ALU, same cycle.
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write enables.
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut.
- ALUSrcA  out  1  0=RD1, 1=PC.
- ALUSrcB  out  2  00=RD2 (shifted), 01=Imm, 10=constant 4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ImmSrc  out  2  equals Op.
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01).
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr.
- State  out  4  current state, for debug and benches.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Codes 10–15 go to FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 with Funct[5]=0→EXECR; Op=00 with Funct[5]=1→EXECI; Op=10→BRANCH; Op=11→FETCH (undefined, no side effects).
  - MEMADR: L=1→MEMRD, L=0→MEMWR.
  - MEMRD→MEMWB→FETCH. MEMWR→FETCH.
  - EXECR/EXECI→ALUWB→FETCH. BRANCH→FETCH.
- Raw per-state controls (unlisted controls are 0, selects are 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1, add.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, add.
  - MEMADR: ALUSrcB=01, add.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1, add.
- ALU decode, applied when ALUOp=1, by cmd:
  - 0100 ADD→00; 0010 SUB→01; 0000 AND→10; 1100 ORR→11.
  - 1010 CMP→01 with RegW suppressed and FlagW forced to 11.
  - Any other cmd→00 with RegW suppressed.
  - FlagW[1] (NZ) = S. FlagW[0] (CV) = S and the command is ADD or SUB.
  - When ALUOp=0: add, FlagW=00.
- Condition evaluation from the stored flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111→0.
- CondExReg is captured only on the rising edge that leaves DECODE. All gating uses CondExReg:
  - RegWrite = RegW & CondExReg.
  - MemWrite = MemW & CondExReg.
  - PCWrite = NextPC | (CondExReg & (Branch | (RegW & Rd==15))).
  - Flag register: NZ loads ALUFlags[3:2] at the end of EXECR/EXECI when FlagW[1] & CondExReg; CV loads ALUFlags[1:0] when FlagW[0] & CondExReg.

## Timing
- Reset:
  - State=FETCH, flags=0000, CondExReg=0.
  - While reset=1, PCWrite/IRWrite/RegWrite/MemWrite are forced 0 and selects show FETCH values.
  - First FETCH occurs in the first cycle after deassertion.
- Cycles per instruction: LDR 5, STR 4, data-processing/CMP 4, B 3, undefined 2.
- Outputs are combinational from the state register, decode inputs and CondExReg. There are no additional output flops.
- Flags written in EXECx are not visible to the current instruction's gating, which uses CondExReg. They are visible to the next instruction's DECODE.
- Reset asserted mid-instruction: state returns to FETCH immediately. A pending MEMWR or ALUWB write is dropped and flags are unchanged.

## Test plan
- Reset held 3 cycles, then released → State=0 and all enables 0 during reset; State sequence 0,1 follows release; IRWrite=1 and PCWrite=1 in the first FETCH.
- ADD R (Cond=1110, Op=00, Funct=001000, Rd=3) → State 0,1,6,8,0; ALUControl=00 in state 6; RegWrite=1 only in state 8; PCWrite=0 in state 8.
- SUBS imm (Funct=100101) with ALUFlags=0100 in EXECI → Z flag set; a following BEQ (Cond=0000, Op=10) → State 0,1,9,0 with PCWrite=1 in state 9. With Z=0, PCWrite=0 in state 9.
- LDR (Op=01, Funct=011001) → State 0,1,2,3,4,0; AdrSrc=1 in state 3; ResultSrc=01 and RegWrite=1 in state 4. STR (Funct=011000) → 0,1,2,5,0 with MemWrite=1 in state 5.
- STRNE (Cond=0001) with Z=1 → MemWrite stays 0 in state 5. ADD with Rd=15 and AL → PCWrite=1 in ALUWB.
- Reset asserted in state 5 with MemWrite=1 → MemWrite drops to 0 asynchronously and State=0. Op=11 → State 0,1,0 with no enables.
